// File: rtl/dm_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access controller:
// FSM state encoding, byte-lane numbering, and the byte merge/extract
// functions used for sb read-modify-write and lb/lbu results.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_WAIT   = 2'd1,
        RMW_MERGE = 2'd2,
        DONE      = 2'd3
    } dm_state_t;

    // Byte lanes within a 32-bit word (little-endian numbering)
    localparam logic [1:0] LANE0 = 2'd0;  // bits [7:0]
    localparam logic [1:0] LANE1 = 2'd1;  // bits [15:8]
    localparam logic [1:0] LANE2 = 2'd2;  // bits [23:16]
    localparam logic [1:0] LANE3 = 2'd3;  // bits [31:24]

    // Replace one byte lane of a word, leaving the other three untouched
    function automatic logic [31:0] byte_merge(
        input logic [31:0] word,
        input logic [7:0]  byte_val,
        input logic [1:0]  lane
    );
        logic [31:0] merged;
        merged = word;
        case (lane)
            LANE0:   merged[7:0]   = byte_val;
            LANE1:   merged[15:8]  = byte_val;
            LANE2:   merged[23:16] = byte_val;
            default: merged[31:24] = byte_val;
        endcase
        return merged;
    endfunction

    // Pick one byte lane and widen it to 32 bits, sign- or zero-extended
    function automatic logic [31:0] byte_extract(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic        is_signed
    );
        logic [7:0] sel;
        case (lane)
            LANE0:   sel = word[7:0];
            LANE1:   sel = word[15:8];
            LANE2:   sel = word[23:16];
            default: sel = word[31:24];
        endcase
        return is_signed ? {{24{sel[7]}}, sel} : {24'h000000, sel};
    endfunction

endpackage

// File: rtl/dm_access_ctrl_ram.sv
// Single-port synchronous word RAM. Read is registered (q valid the cycle
// after idx is presented); a write on the same edge returns the old word.
// Contents are deliberately not reset so the array maps onto block RAM.
module dm_access_ctrl_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      q
);

    logic [31:0] mem_reg [DEPTH_WORDS];

    // Write commits on the edge; read-first registered output
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[idx] <= wdata;
        end
        q <= mem_reg[idx];
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access controller. Word stores complete with no
// stall; loads and byte stores take a RAM read cycle plus a completion
// cycle, stalling the pipeline meanwhile. Byte stores are done as a
// read-modify-write so the RAM only needs a single 32-bit write port.
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dm_addr,
    input  logic [31:0] busB,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic        IsByteB,
    input  logic        IsByteL,
    input  logic        LoadSigned,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data
);

    dm_state_t        state_reg;
    dm_state_t        state_next;
    logic [31:0]      load_data_reg;
    logic [31:0]      load_data_next;

    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic             ram_we;
    logic [31:0]      ram_wdata;
    logic [31:0]      ram_q;

    // Upper address bits fold away so accesses wrap modulo the RAM size
    logic             unused_addr_bits;
    assign unused_addr_bits = ^dm_addr[31:IDX_W+2];

    assign word_idx  = dm_addr[IDX_W+1:2];
    assign lane      = dm_addr[1:0];
    assign load_data = load_data_reg;

    dm_access_ctrl_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .idx   (word_idx),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    // State register; reset from any state returns to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: a store always wins over a simultaneous load request
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (MemWr) begin
                    state_next = IsByteB ? RMW_MERGE : IDLE;
                end else if (MemRd) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT:   state_next = DONE;
            RMW_MERGE: state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Outputs and RAM write control; reset masks both stall/done and any write
    always_comb begin
        stall     = 1'b0;
        done      = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = busB;
        case (state_reg)
            IDLE: begin
                if (MemWr) begin
                    if (IsByteB) begin
                        stall = 1'b1;
                    end else begin
                        ram_we = 1'b1;
                    end
                end else if (MemRd) begin
                    stall = 1'b1;
                end
            end
            RD_WAIT: begin
                stall = 1'b1;
            end
            RMW_MERGE: begin
                stall     = 1'b1;
                ram_we    = 1'b1;
                ram_wdata = byte_merge(ram_q, busB[7:0], lane);
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
        if (rst) begin
            stall  = 1'b0;
            done   = 1'b0;
            ram_we = 1'b0;
        end
    end

    // Load result is captured once, in RD_WAIT, and held until the next load
    always_comb begin
        load_data_next = load_data_reg;
        if (state_reg == RD_WAIT) begin
            load_data_next = IsByteL ? byte_extract(ram_q, lane, LoadSigned) : ram_q;
        end
    end

    // Load data register
    always_ff @(posedge clk) begin
        if (rst) begin
            load_data_reg <= 32'h0;
        end else begin
            load_data_reg <= load_data_next;
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl. Stimulus tasks push the expected
// completion of each multi-cycle access onto a queue; a monitor pops and
// compares whenever done is seen. Stall counts are checked by the tasks.
module tb_dm_access_ctrl;

    typedef struct {
        bit          is_load;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dm_addr;
    logic [31:0] busB;
    logic        MemRd;
    logic        MemWr;
    logic        IsByteB;
    logic        IsByteL;
    logic        LoadSigned;
    logic        stall;
    logic        done;
    logic [31:0] load_data;

    int          checks   = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    logic [31:0] last_load = 32'h0;

    always #5 clk = ~clk;

    dm_access_ctrl #(
        .DEPTH_WORDS (1024),
        .IDX_W       (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dm_addr    (dm_addr),
        .busB       (busB),
        .MemRd      (MemRd),
        .MemWr      (MemWr),
        .IsByteB    (IsByteB),
        .IsByteL    (IsByteL),
        .LoadSigned (LoadSigned),
        .stall      (stall),
        .done       (done),
        .load_data  (load_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding access
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no pending access");
                end else begin
                    e = exp_q.pop_front();
                    check(e.is_load ? "load_data" : "load_data_held_after_store", load_data, e.data);
                end
            end
        end
    end

    task automatic clear_inputs();
        MemRd = 1'b0; MemWr = 1'b0; IsByteB = 1'b0; IsByteL = 1'b0; LoadSigned = 1'b0;
    endtask

    // Count stall cycles until done, bounded; then release the request
    task automatic wait_done(input string name);
        int  n_stall = 0;
        bit  seen    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (stall === 1'b1) n_stall++;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done expected done within 10 cycles", name);
        end
        check({name, "_stall_cycles"}, 32'(n_stall), 32'd2);
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic do_sw(input logic [31:0] addr, input logic [31:0] data, input logic rd);
        $display("sw   addr=0x%08h data=0x%08h MemRd=%0d", addr, data, rd);
        dm_addr = addr; busB = data; MemWr = 1'b1; MemRd = rd; IsByteB = 1'b0;
        @(negedge clk);
        check("sw_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic do_sb(input logic [31:0] addr, input logic [7:0] b);
        exp_t e;
        $display("sb   addr=0x%08h byte=0x%02h", addr, b);
        e.is_load = 1'b0; e.data = last_load;
        exp_q.push_back(e);
        dm_addr = addr; busB = {24'h123456, b}; MemWr = 1'b1; IsByteB = 1'b1;
        wait_done("sb");
    endtask

    task automatic do_ld(input logic [31:0] addr, input logic is_byte, input logic sgn,
                         input logic [31:0] expv);
        exp_t e;
        $display("%s addr=0x%08h expect=0x%08h", is_byte ? (sgn ? "lb  " : "lbu ") : "lw  ", addr, expv);
        e.is_load = 1'b1; e.data = expv;
        exp_q.push_back(e);
        last_load = expv;
        dm_addr = addr; MemRd = 1'b1; IsByteL = is_byte; LoadSigned = sgn;
        wait_done("load");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        dm_addr = 32'h0; busB = 32'h0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_stall", {31'h0, stall}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_load_data", load_data, 32'h0);
        @(posedge clk); #1;

        // 1: word store then word load
        do_sw(32'h10, 32'hDEADBEEF, 1'b0);
        do_ld(32'h10, 1'b0, 1'b0, 32'hDEADBEEF);

        // 2: byte stores on lanes, merged readback
        do_sw(32'h20, 32'h11223344, 1'b0);
        do_sb(32'h21, 8'hAA);
        do_sb(32'h23, 8'hAA);
        do_ld(32'h20, 1'b0, 1'b0, 32'hAA22AA44);
        do_sw(32'h24, 32'h0, 1'b0);
        do_sb(32'h24, 8'h01);
        do_sb(32'h25, 8'h02);
        do_sb(32'h26, 8'h03);
        do_sb(32'h27, 8'h04);
        do_ld(32'h24, 1'b0, 1'b0, 32'h04030201);

        // 3: lb / lbu
        do_sw(32'h30, 32'h80FF7F01, 1'b0);
        do_ld(32'h33, 1'b1, 1'b1, 32'hFFFFFF80);
        do_ld(32'h33, 1'b1, 1'b0, 32'h00000080);
        do_ld(32'h31, 1'b1, 1'b1, 32'h0000007F);
        do_ld(32'h32, 1'b1, 1'b0, 32'h000000FF);
        do_ld(32'h32, 1'b1, 1'b1, 32'hFFFFFFFF);
        do_ld(32'h30, 1'b1, 1'b1, 32'h00000001);

        // 4: address wrap and ignored word misalignment
        do_sw(32'h1000, 32'h5, 1'b0);
        do_ld(32'h0, 1'b0, 1'b0, 32'h5);
        do_ld(32'h3, 1'b0, 1'b0, 32'h5);

        // 5: reset during RMW_MERGE suppresses the write
        do_sw(32'h40, 32'h12345678, 1'b0);
        $display("sb   addr=0x%08h byte=0x99 with rst in merge cycle", 32'h40);
        dm_addr = 32'h40; busB = 32'h99; MemWr = 1'b1; IsByteB = 1'b1;
        @(negedge clk);
        check("rmw_issue_stall", {31'h0, stall}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        check("post_rst_stall", {31'h0, stall}, 32'h0);
        check("post_rst_done", {31'h0, done}, 32'h0);
        check("post_rst_load_data", load_data, 32'h0);
        last_load = 32'h0;
        @(posedge clk); #1;
        do_ld(32'h40, 1'b0, 1'b0, 32'h12345678);

        // 6: simultaneous MemRd & MemWr is a plain store
        do_sw(32'h50, 32'h0000ABCD, 1'b1);
        @(negedge clk);
        check("load_data_after_rdwr", load_data, 32'h12345678);
        check("rdwr_no_done", {31'h0, done}, 32'h0);
        @(posedge clk); #1;
        do_ld(32'h50, 1'b0, 1'b0, 32'h0000ABCD);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
